// File: rtl/maze_move_ctrl.sv
// Cell-to-cell player movement sequencer for the maze display: decodes the
// joystick, checks the target wall edge, animates one cell per accepted move.
module maze_move_ctrl #(
  parameter int N        = 5,
  parameter int CELL     = 80,
  parameter int STEP_PX  = 4,
  parameter int ORIGIN_X = 120,
  parameter int ORIGIN_Y = 0,
  parameter int PAD      = 4,
  parameter int DEAD     = 4
) (
  input  logic             in_clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             restart,
  input  logic [9:0]       movementData,
  input  logic [N*N-1:0]   wall_h,
  input  logic [N*N-1:0]   wall_v,
  output logic [10:0]      h_min,
  output logic [10:0]      v_min,
  output logic [2:0]       cell_col,
  output logic [2:0]       cell_row,
  output logic             busy,
  output logic             blocked,
  output logic             goal_reached,
  output logic [15:0]      move_count
);
  localparam int          IW     = $clog2(N*N);
  localparam logic [2:0]  LAST   = 3'(N-1);
  localparam logic [10:0] H0     = 11'(ORIGIN_X + PAD);
  localparam logic [10:0] V_TOP  = 11'(ORIGIN_Y + PAD);
  localparam logic [10:0] V0     = 11'(ORIGIN_Y + (N-1)*CELL + PAD);
  localparam logic [10:0] STEP   = 11'(STEP_PX);
  localparam logic [10:0] CELL_W = 11'(CELL);
  localparam logic [5:0]  DZ     = 6'(DEAD);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_MOVE, S_GOAL} state_t;
  typedef enum logic [1:0] {D_RIGHT, D_LEFT, D_DOWN, D_UP} dir_t;

  state_t      state_q, state_d;
  dir_t        dir_q, dir_d;
  logic [2:0]  col_q, col_d, row_q, row_d;
  logic [10:0] h_q, h_d, v_q, v_d, rem_q, rem_d;
  logic [15:0] cnt_q, cnt_d;
  logic        blocked_q, blocked_d;

  // Joystick decode: magnitudes carry an extra bit so -16 reads as 16.
  logic [4:0] jx, jy;
  logic [5:0] mag_x, mag_y;
  logic       h_act, v_act, use_h, req_vld;
  dir_t       req_dir;

  assign jx      = movementData[9:5];
  assign jy      = movementData[4:0];
  assign mag_x   = jx[4] ? (6'd0 - {1'b1, jx}) : {1'b0, jx};
  assign mag_y   = jy[4] ? (6'd0 - {1'b1, jy}) : {1'b0, jy};
  assign h_act   = mag_y > DZ;
  assign v_act   = mag_x > DZ;
  assign req_vld = h_act | v_act;
  assign use_h   = h_act && (!v_act || (mag_y >= mag_x));
  assign req_dir = use_h ? (jy[4] ? D_RIGHT : D_LEFT)
                         : (jx[4] ? D_DOWN  : D_UP);

  // Edge check for the latched direction; border edges are always walls.
  int          base;
  logic [IW-1:0] wall_idx;
  logic        wall_blk;

  always_comb begin
    base     = N*int'(col_q) + int'(row_q);
    wall_idx = '0;
    wall_blk = 1'b1;
    case (dir_q)
      D_RIGHT: if (col_q != LAST) begin
        wall_idx = IW'(base);
        wall_blk = wall_v[wall_idx];
      end
      D_LEFT: if (col_q != 3'd0) begin
        wall_idx = IW'(base - N);
        wall_blk = wall_v[wall_idx];
      end
      D_DOWN: if (row_q != LAST) begin
        wall_idx = IW'(base);
        wall_blk = wall_h[wall_idx];
      end
      D_UP: if (row_q != 3'd0) begin
        wall_idx = IW'(base - 1);
        wall_blk = wall_h[wall_idx];
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    col_d     = col_q;
    row_d     = row_q;
    h_d       = h_q;
    v_d       = v_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    blocked_d = 1'b0;
    if (restart) begin
      state_d = S_IDLE;
      col_d   = 3'd0;
      row_d   = LAST;
      h_d     = H0;
      v_d     = V0;
      rem_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: if (frame_tick && req_vld) begin
          dir_d   = req_dir;
          state_d = S_CHECK;
        end
        S_CHECK: if (wall_blk) begin
          blocked_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          rem_d   = CELL_W;
          state_d = S_MOVE;
        end
        S_MOVE: if (frame_tick) begin
          rem_d = rem_q - STEP;
          case (dir_q)
            D_RIGHT: h_d = h_q + STEP;
            D_LEFT:  h_d = h_q - STEP;
            D_DOWN:  v_d = v_q + STEP;
            D_UP:    v_d = v_q - STEP;
          endcase
          if (rem_d == '0) begin
            case (dir_q)
              D_RIGHT: col_d = col_q + 3'd1;
              D_LEFT:  col_d = col_q - 3'd1;
              D_DOWN:  row_d = row_q + 3'd1;
              D_UP:    row_d = row_q - 3'd1;
            endcase
            // Snap to the cell grid on arrival so the square always lands exactly.
            h_d = H0 + 11'(col_d) * CELL_W;
            v_d = V_TOP + 11'(row_d) * CELL_W;
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
            state_d = ((col_d == LAST) && (row_d == 3'd0)) ? S_GOAL : S_IDLE;
          end
        end
        S_GOAL: state_d = S_GOAL;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge in_clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      dir_q     <= D_RIGHT;
      col_q     <= 3'd0;
      row_q     <= LAST;
      h_q       <= H0;
      v_q       <= V0;
      rem_q     <= '0;
      cnt_q     <= '0;
      blocked_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      col_q     <= col_d;
      row_q     <= row_d;
      h_q       <= h_d;
      v_q       <= v_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      blocked_q <= blocked_d;
    end
  end

  assign h_min        = h_q;
  assign v_min        = v_q;
  assign cell_col     = col_q;
  assign cell_row     = row_q;
  assign busy         = (state_q == S_CHECK) || (state_q == S_MOVE);
  assign blocked      = blocked_q;
  assign goal_reached = (state_q == S_GOAL);
  assign move_count   = cnt_q;
endmodule

// File: tb/tb_maze_move_ctrl.sv
// Scoreboard bench for maze_move_ctrl: each request pushes its expected cell
// outcome; the monitor pops and compares whenever busy falls.
module tb_maze_move_ctrl;
  localparam int N = 5;
  localparam logic [9:0] R8 = 10'b00000_11000;
  localparam logic [9:0] L8 = 10'b00000_01000;
  localparam logic [9:0] D8 = 10'b11000_00000;
  localparam logic [9:0] U8 = 10'b01000_00000;

  logic          in_clk = 1'b0;
  logic          reset, frame_tick, restart;
  logic [9:0]    movementData;
  logic [N*N-1:0] wall_h, wall_v;
  logic [10:0]   h_min, v_min;
  logic [2:0]    cell_col, cell_row;
  logic          busy, blocked, goal_reached;
  logic [15:0]   move_count;

  maze_move_ctrl dut (
    .in_clk(in_clk), .reset(reset), .frame_tick(frame_tick), .restart(restart),
    .movementData(movementData), .wall_h(wall_h), .wall_v(wall_v),
    .h_min(h_min), .v_min(v_min), .cell_col(cell_col), .cell_row(cell_row),
    .busy(busy), .blocked(blocked), .goal_reached(goal_reached),
    .move_count(move_count)
  );

  always #5 in_clk = ~in_clk;

  typedef struct {
    logic blk;
    int   col, row, h, v, cnt;
    logic goal;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0, n_bad = 0, blk_pulses = 0;
  int   mc, mr, mcnt;
  logic busy_d1 = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_cell(input logic blk);
    exp_t e;
    e.blk  = blk;
    e.col  = mc;
    e.row  = mr;
    e.h    = 120 + 80*mc + 4;
    e.v    = 80*mr + 4;
    e.cnt  = mcnt;
    e.goal = (mc == N-1) && (mr == 0);
    sb.push_back(e);
  endtask

  // dir: 0 right, 1 left, 2 down, 3 up
  task automatic model_req(input int dir);
    logic b;
    b = 1'b1;
    case (dir)
      0: if (mc != N-1) b = wall_v[N*mc + mr];
      1: if (mc != 0)   b = wall_v[N*(mc-1) + mr];
      2: if (mr != N-1) b = wall_h[N*mc + mr];
      default: if (mr != 0) b = wall_h[N*mc + mr - 1];
    endcase
    if (!b) begin
      case (dir)
        0: mc++;
        1: mc--;
        2: mr++;
        default: mr--;
      endcase
      mcnt++;
    end
    expect_cell(b);
  endtask

  task automatic model_restart();
    mc = 0; mr = N-1; mcnt = 0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge in_clk);
    frame_tick = 1'b0;
  endtask

  // Issue one request, then tick every cycle until the DUT settles.
  task automatic req(input logic [9:0] md, input int dir);
    int n = 0;
    model_req(dir);
    movementData = md;
    tick();
    movementData = '0;
    while (busy === 1'b1 && n < 60) begin
      tick();
      n++;
    end
    check("req_settle", busy, 1'b0);
  endtask

  task automatic check_start(input string tag);
    check({tag, "_col"}, cell_col, 0);
    check({tag, "_row"}, cell_row, 4);
    check({tag, "_h"}, h_min, 124);
    check({tag, "_v"}, v_min, 324);
    check({tag, "_cnt"}, move_count, 0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_goal"}, goal_reached, 1'b0);
  endtask

  always @(negedge in_clk) begin
    exp_t e;
    if (blocked === 1'b1) blk_pulses++;
    if (busy_d1 === 1'b1 && busy === 1'b0) begin
      if (sb.size() == 0) check("sb_underflow", sb.size(), 1);
      else begin
        e = sb.pop_front();
        check("ev_blocked", blocked, e.blk);
        check("ev_col", cell_col, e.col);
        check("ev_row", cell_row, e.row);
        check("ev_h", h_min, e.h);
        check("ev_v", v_min, e.v);
        check("ev_cnt", move_count, e.cnt);
        check("ev_goal", goal_reached, e.goal);
      end
    end
    busy_d1 = busy;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    int b0;
    reset = 1'b1; frame_tick = 1'b0; restart = 1'b0;
    movementData = '0; wall_h = '0; wall_v = '0;
    repeat (2) @(negedge in_clk);
    reset = 1'b0;
    model_restart();
    check_start("rst");
    check("rst_blocked", blocked, 1'b0);

    // jy = -4 sits inside the dead zone
    movementData = 10'b00000_11100;
    repeat (3) begin
      tick();
      check("dz_busy", busy, 1'b0);
      check("dz_h", h_min, 124);
    end
    movementData = '0;

    // One RIGHT move with per-frame pixel trace
    model_req(0);
    movementData = R8;
    tick();
    movementData = '0;
    check("chk_busy", busy, 1'b1);
    @(negedge in_clk);
    for (int k = 1; k <= 20; k++) begin
      tick();
      check("step_h", h_min, 124 + 4*k);
    end
    check("step_busy", busy, 1'b0);

    // jx = -16 beats jy = +8: DOWN wins and hits the bottom border
    req(10'b10000_01000, 2);

    restart = 1'b1;
    @(negedge in_clk);
    restart = 1'b0;
    model_restart();
    check_start("rs1");

    // Wall on the right edge of the start cell
    wall_v[4] = 1'b1;
    b0 = blk_pulses;
    req(R8, 0);
    repeat (2) @(negedge in_clk);
    check("wall_pulses", blk_pulses - b0, 1);
    check("wall_h", h_min, 124);
    check("wall_cnt", move_count, 0);
    wall_v = '0;

    // Border-blocked LEFT and DOWN at the start cell
    b0 = blk_pulses;
    req(L8, 1);
    req(D8, 2);
    repeat (2) @(negedge in_clk);
    check("border_pulses", blk_pulses - b0, 2);

    // Four RIGHT (first one an axis tie), a wall-blocked UP, then four UP
    req(10'b00110_11010, 0);
    repeat (3) req(R8, 0);
    wall_h[N*4 + 3] = 1'b1;
    req(U8, 3);
    wall_h = '0;
    req(10'b00111_11010, 3);
    repeat (3) req(U8, 3);
    check("goal_flag", goal_reached, 1'b1);
    check("goal_cnt", move_count, 8);

    // Stick ignored in GOAL
    movementData = L8;
    repeat (3) tick();
    movementData = '0;
    check("goal_hold_busy", busy, 1'b0);
    check("goal_hold_col", cell_col, 4);
    check("goal_hold_h", h_min, 444);
    check("goal_hold_v", v_min, 4);
    check("goal_hold_flag", goal_reached, 1'b1);

    restart = 1'b1;
    @(negedge in_clk);
    restart = 1'b0;
    model_restart();
    check_start("rs2");

    // restart mid-MOVE with 40 px remaining
    expect_cell(1'b0);
    movementData = R8;
    tick();
    movementData = '0;
    @(negedge in_clk);
    repeat (10) tick();
    check("mid_h", h_min, 164);
    check("mid_busy", busy, 1'b1);
    restart = 1'b1;
    @(negedge in_clk);
    restart = 1'b0;
    check_start("rs_mid");

    // reset mid-MOVE
    expect_cell(1'b0);
    movementData = R8;
    tick();
    movementData = '0;
    @(negedge in_clk);
    repeat (10) tick();
    check("mid2_h", h_min, 164);
    reset = 1'b1;
    @(negedge in_clk);
    reset = 1'b0;
    check_start("rst_mid");

    // Clean move after the aborted one counts from zero
    req(R8, 0);
    check("post_cnt", move_count, 1);

    repeat (3) @(negedge in_clk);
    check("sb_left", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
